mult_32_bit_seq: RTL



---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_32_bit_seq_if.sv | 30 +++
 rtl/inv_32.sv | 14 +
 rtl/mult_datapath.sv | 104 ++++++++++
 rtl/mult_32_bit_seq.sv | 117 +++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_e    : FSM encoding (IDLE/CALC/NEG/FIN); NEG is only reachable
//                when the design is built with MULT_SIGNED_EN defined.
//   MULT_WIDTH : default operand width.
//   CNT_W      : iteration counter width (MULT_WIDTH iterations).
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 32;
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NEG  = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/mult_32_bit_seq_if.sv
// Request/result bundle of the sequential multiplier.
//   START   : request a multiply (master -> slave)
//   A, B    : multiplicand / multiplier (master -> slave)
//   PRODUCT : 2*WIDTH-bit result register (slave -> master)
//   BUSY    : operation in progress (slave -> master)
//   DONE    : one-cycle completion pulse (slave -> master)
interface mult_32_bit_seq_if
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
);

  logic                 START;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   PRODUCT;
  logic                 BUSY;
  logic                 DONE;

  modport master (
    output START, A, B,
    input  PRODUCT, BUSY, DONE
  );

  modport slave (
    input  START, A, B,
    output PRODUCT, BUSY, DONE
  );

endinterface

// File: rtl/inv_32.sv
// 32-bit bitwise inverter stage, used to form two's-complement negations
// in the signed build (compiled only when MULT_SIGNED_EN is defined).
//   din  : 32-bit input
//   dout : bitwise complement of din
`ifdef MULT_SIGNED_EN
module inv_32 (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = ~din;

endmodule
`endif

// File: rtl/mult_datapath.sv
// Shift-add datapath: multiplicand/multiplier registers, a 2*WIDTH+1-bit
// accumulator, the WIDTH+1-bit adder and the right shifter.
// Optional macro MULT_SIGNED_EN: operands are converted to magnitudes at
// capture and the product is conditionally negated by the neg strobe.
//   clk, rst_n : clock, async active-low reset
//   load       : capture a/b, clear the accumulator
//   step       : one shift-add iteration
//   neg        : (signed build only) negate product if result sign is 1
//   a, b       : operands
//   result     : low 2*WIDTH bits of the accumulator
module mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
`ifdef MULT_SIGNED_EN
  input  logic               neg,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result
);

  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [WIDTH:0]     sum_hi;
  logic [WIDTH-1:0]   a_op, b_op;

`ifdef MULT_SIGNED_EN
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   a_inv, b_inv;
  logic [WIDTH-1:0]   acc_inv_hi, acc_inv_lo;
  logic [2*WIDTH-1:0] acc_neg;

  inv_32 u_inv_a      (.din(a),                     .dout(a_inv));
  inv_32 u_inv_b      (.din(b),                     .dout(b_inv));
  inv_32 u_inv_acc_hi (.din(acc_q[2*WIDTH-1:WIDTH]), .dout(acc_inv_hi));
  inv_32 u_inv_acc_lo (.din(acc_q[WIDTH-1:0]),       .dout(acc_inv_lo));

  // Magnitudes; the most-negative value maps onto itself, which is the
  // correct unsigned magnitude.
  assign a_op    = a[WIDTH-1] ? a_inv + WIDTH'(1) : a;
  assign b_op    = b[WIDTH-1] ? b_inv + WIDTH'(1) : b;
  assign acc_neg = {acc_inv_hi, acc_inv_lo} + (2*WIDTH)'(1);
`else
  assign a_op = a;
  assign b_op = b;
`endif

  // acc_q[2*WIDTH] is always zero between iterations; including it keeps
  // the adder a full WIDTH+1 bits so the carry lands in the extra bit.
  assign sum_hi = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
`ifdef MULT_SIGNED_EN
    sign_d  = sign_q;
`endif
    if (load) begin
      acc_d   = '0;
      mcand_d = a_op;
      mplr_d  = b_op;
`ifdef MULT_SIGNED_EN
      sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
`endif
    end else if (step) begin
      acc_d  = {(mplr_q[0] ? sum_hi : acc_q[2*WIDTH:WIDTH]), acc_q[WIDTH-1:0]} >> 1;
      mplr_d = mplr_q >> 1;
    end
`ifdef MULT_SIGNED_EN
    else if (neg) begin
      if (sign_q) acc_d = {1'b0, acc_neg};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
`ifdef MULT_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
`ifdef MULT_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign result = acc_q[2*WIDTH-1:0];

endmodule

// File: rtl/mult_32_bit_seq.sv
// Multi-cycle WIDTH x WIDTH -> 2*WIDTH shift-add multiplier (one multiplier
// bit per clock). FSM and iteration counter live here; arithmetic lives in
// mult_datapath.
// Optional macro MULT_SIGNED_EN: two's-complement operands, extra NEG state
// (latency WIDTH+2 instead of WIDTH+1).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mult_32_bit_seq_if (START, A, B, PRODUCT, BUSY, DONE)
module mult_32_bit_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_32_bit_seq_if.slave bus
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic                 dp_load;
  logic                 dp_step;
`ifdef MULT_SIGNED_EN
  logic                 dp_neg;
`endif
  logic [2*WIDTH-1:0]   dp_result;

  mult_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (dp_load),
    .step   (dp_step),
`ifdef MULT_SIGNED_EN
    .neg    (dp_neg),
`endif
    .a      (bus.A),
    .b      (bus.B),
    .result (dp_result)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    dp_load   = 1'b0;
    dp_step   = 1'b0;
`ifdef MULT_SIGNED_EN
    dp_neg    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          dp_load   = 1'b1;
          product_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = CALC;
        end
      end
      CALC: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef MULT_SIGNED_EN
          state_d = NEG;
`else
          state_d = FIN;
`endif
        end
      end
`ifdef MULT_SIGNED_EN
      NEG: begin
        dp_neg  = 1'b1;
        state_d = FIN;
      end
`endif
      FIN: begin
        // Outputs are registered, so DONE/PRODUCT appear in the cycle after
        // FIN, which is already IDLE; START is not looked at in FIN.
        done_d    = 1'b1;
        busy_d    = 1'b0;
        product_d = dp_result;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign bus.PRODUCT = product_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;

endmodule
